// File: rtl/cmprs_status_irq.sv
// Compressor status consumer: frame-done detection, frame counter, maskable interrupt,
// flush watchdog and a sequence-numbered status word sent over a valid/ack handshake.
module cmprs_status_irq #(
  parameter int FRAME_CNT_BITS = 4,
  parameter int SEQ_BITS       = 6,
  parameter int TIMEOUT_BITS   = 16,
  parameter int FLUSH_TIMEOUT  = 50000
) (
  input  logic                               mclk,
  input  logic                               mrst_n,
  input  logic [2:0]                         status,
  input  logic                               eof_written,
  input  logic                               cmd_we,
  input  logic [3:0]                         cmd_data,
  input  logic                               status_ack,
  output logic                               irq,
  output logic                               done_pulse,
  output logic [FRAME_CNT_BITS-1:0]          frame_cnt,
  output logic                               status_valid,
  output logic [SEQ_BITS+FRAME_CNT_BITS+5:0] status_word
);

  localparam int FW = FRAME_CNT_BITS + 6;
  localparam int SW = SEQ_BITS + FW;
  localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(FLUSH_TIMEOUT - 1);
  localparam logic [TIMEOUT_BITS-1:0] TO_MAX  = TIMEOUT_BITS'(FLUSH_TIMEOUT);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                    state_r, state_next_s;
  logic                      done_pulse_r;
  logic [FRAME_CNT_BITS-1:0] frame_cnt_r;
  logic                      irq_pending_r, irq_en_r, irq_r;
  logic                      timeout_err_r;
  logic [TIMEOUT_BITS-1:0]   wd_cnt_r;
  logic [1:0]                mode_r;
  logic [FW-1:0]             prev_fields_r;
  logic                      change_pending_r;
  logic [SEQ_BITS-1:0]       seq_r;
  logic                      status_valid_r;
  logic [SW-1:0]             status_word_r;

  logic          irq_clr_s, irq_dis_s, irq_ena_s;
  logic          timeout_hit_s;
  logic          load_s, ack_s;
  logic [FW-1:0] fields_s;

  assign timeout_hit_s = status[2] & (wd_cnt_r == TO_LAST);
  assign fields_s      = {frame_cnt_r, timeout_err_r, irq_en_r, irq_pending_r, status};

  // Interrupt command decode
  always_comb begin
    irq_clr_s = 1'b0;
    irq_dis_s = 1'b0;
    irq_ena_s = 1'b0;
    if (cmd_we) begin
      case (cmd_data[1:0])
        2'd1:    irq_clr_s = 1'b1;
        2'd2:    irq_dis_s = 1'b1;
        2'd3:    irq_ena_s = 1'b1;
        default: irq_clr_s = 1'b0;
      endcase
    end else begin
      irq_clr_s = 1'b0;
    end
  end

  // Frame done, frame counter, interrupt and watchdog state
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      done_pulse_r  <= 1'b0;
      frame_cnt_r   <= '0;
      irq_pending_r <= 1'b0;
      irq_en_r      <= 1'b0;
      irq_r         <= 1'b0;
      timeout_err_r <= 1'b0;
      wd_cnt_r      <= '0;
    end else begin
      done_pulse_r <= eof_written & status[2];
      if (done_pulse_r) frame_cnt_r <= frame_cnt_r + FRAME_CNT_BITS'(1);
      // a new event outranks a clear arriving in the same cycle
      if (done_pulse_r || timeout_hit_s) irq_pending_r <= 1'b1;
      else if (irq_clr_s)                irq_pending_r <= 1'b0;
      if (irq_ena_s)      irq_en_r <= 1'b1;
      else if (irq_dis_s) irq_en_r <= 1'b0;
      irq_r <= irq_pending_r & irq_en_r;
      if (timeout_hit_s)  timeout_err_r <= 1'b1;
      else if (irq_clr_s) timeout_err_r <= 1'b0;
      if (!status[2])             wd_cnt_r <= '0;
      else if (wd_cnt_r != TO_MAX) wd_cnt_r <= wd_cnt_r + TIMEOUT_BITS'(1);
    end
  end

  // Sender next-state logic
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    ack_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (mode_r == 2'd1 || (mode_r[1] && change_pending_r)) begin
          load_s       = 1'b1;
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (status_ack) begin
          ack_s        = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = SEND;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Sender state, mode, change tracking and the outgoing word
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_r          <= IDLE;
      mode_r           <= 2'd0;
      prev_fields_r    <= '0;
      change_pending_r <= 1'b0;
      seq_r            <= '0;
      status_valid_r   <= 1'b0;
      status_word_r    <= '0;
    end else begin
      state_r       <= state_next_s;
      prev_fields_r <= fields_s;
      // a fresh command write overrides single-shot self-clear
      if (cmd_we)                        mode_r <= cmd_data[3:2];
      else if (load_s && mode_r == 2'd1) mode_r <= 2'd0;
      // the loaded word already carries this cycle's fields, so load clears
      if (load_s)                         change_pending_r <= 1'b0;
      else if (fields_s != prev_fields_r) change_pending_r <= 1'b1;
      if (load_s) begin
        status_word_r  <= {seq_r, fields_s};
        status_valid_r <= 1'b1;
      end else if (ack_s) begin
        status_valid_r <= 1'b0;
        seq_r          <= seq_r + SEQ_BITS'(1);
      end
    end
  end

  assign irq          = irq_r;
  assign done_pulse   = done_pulse_r;
  assign frame_cnt    = frame_cnt_r;
  assign status_valid = status_valid_r;
  assign status_word  = status_word_r;

endmodule

// File: tb/tb_cmprs_status_irq.sv
// Directed bench for cmprs_status_irq with hand-computed expectations (FLUSH_TIMEOUT=20).
module tb_cmprs_status_irq;

  logic        mclk = 1'b0;
  logic        mrst_n;
  logic [2:0]  status;
  logic        eof_written;
  logic        cmd_we;
  logic [3:0]  cmd_data;
  logic        status_ack;
  logic        irq;
  logic        done_pulse;
  logic [3:0]  frame_cnt;
  logic        status_valid;
  logic [15:0] status_word;

  int n_cmp  = 0;
  int n_fail = 0;

  cmprs_status_irq #(
    .FRAME_CNT_BITS(4), .SEQ_BITS(6), .TIMEOUT_BITS(16), .FLUSH_TIMEOUT(20)
  ) dut (
    .mclk(mclk), .mrst_n(mrst_n), .status(status), .eof_written(eof_written),
    .cmd_we(cmd_we), .cmd_data(cmd_data), .status_ack(status_ack), .irq(irq),
    .done_pulse(done_pulse), .frame_cnt(frame_cnt), .status_valid(status_valid),
    .status_word(status_word)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    mrst_n = 1'b0; status = 3'b000; eof_written = 1'b0;
    cmd_we = 1'b0; cmd_data = 4'h0; status_ack = 1'b0;
    #3;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_done", 32'(done_pulse), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_valid", 32'(status_valid), 32'd0);
    chk("rst_word", 32'(status_word), 32'd0);
    step(); step();
    mrst_n = 1'b1;
    step();

    // frame done + enable
    status = 3'b100; eof_written = 1'b1; cmd_we = 1'b1; cmd_data = 4'h3;
    step();
    chk("done_lat", 32'(done_pulse), 32'd1);
    chk("frame_pre", 32'(frame_cnt), 32'd0);
    status = 3'b000; eof_written = 1'b0; cmd_we = 1'b0;
    step();
    chk("done_one", 32'(done_pulse), 32'd0);
    chk("frame_1", 32'(frame_cnt), 32'd1);
    chk("irq_lat", 32'(irq), 32'd0);
    step();
    chk("irq_set", 32'(irq), 32'd1);
    cmd_we = 1'b1; cmd_data = 4'h1;
    step();
    chk("irq_clr_lat", 32'(irq), 32'd1);
    cmd_we = 1'b0;
    step();
    chk("irq_clr", 32'(irq), 32'd0);
    chk("mode0_nosend", 32'(status_valid), 32'd0);

    // wrap after 16 frames
    for (int i = 0; i < 15; i++) begin
      status = 3'b100; eof_written = 1'b1;
      step();
      status = 3'b000; eof_written = 1'b0;
      step();
      if (i == 13) chk("frame_15", 32'(frame_cnt), 32'd15);
    end
    chk("frame_wrap", 32'(frame_cnt), 32'd0);
    chk("irq_frames", 32'(irq), 32'd1);
    status = 3'b010; eof_written = 1'b1;
    step();
    chk("no_done", 32'(done_pulse), 32'd0);
    status = 3'b000; eof_written = 1'b0;
    step();
    chk("no_frame", 32'(frame_cnt), 32'd0);
    cmd_we = 1'b1; cmd_data = 4'h1;
    step();
    cmd_we = 1'b0;
    step();
    chk("irq_clr2", 32'(irq), 32'd0);

    // flush watchdog
    status = 3'b100;
    for (int i = 0; i < 19; i++) step();
    chk("wd_19", 32'(irq), 32'd0);
    step();
    chk("wd_20", 32'(irq), 32'd0);
    step();
    chk("wd_irq", 32'(irq), 32'd1);

    // single-shot word with delayed ack
    cmd_we = 1'b1; cmd_data = 4'h4;
    step();
    cmd_we = 1'b0;
    step();
    chk("s1_valid", 32'(status_valid), 32'd1);
    chk("s1_word", 32'(status_word), 32'h003C);
    status = 3'b110;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s1_hold_v", 32'(status_valid), 32'd1);
      chk("s1_hold_w", 32'(status_word), 32'h003C);
    end
    status_ack = 1'b1;
    step();
    chk("s1_ack", 32'(status_valid), 32'd0);
    status_ack = 1'b0;
    step();
    chk("s1_idle1", 32'(status_valid), 32'd0);
    step();
    chk("s1_idle2", 32'(status_valid), 32'd0);

    // clear error while still flushing; no repeat event
    cmd_we = 1'b1; cmd_data = 4'h1;
    step();
    cmd_we = 1'b0;
    step();
    chk("wd_clr", 32'(irq), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wd_norep", 32'(irq), 32'd0);
    end
    cmd_we = 1'b1; cmd_data = 4'h5;
    step();
    cmd_we = 1'b0;
    step();
    chk("s2_valid", 32'(status_valid), 32'd1);
    chk("s2_word", 32'(status_word), 32'h0416);
    status_ack = 1'b1; status = 3'b000;
    step();
    chk("s2_ack", 32'(status_valid), 32'd0);
    status_ack = 1'b0;

    // done pulse coincident with clear: set wins
    status = 3'b100; eof_written = 1'b1;
    step();
    status = 3'b000; eof_written = 1'b0; cmd_we = 1'b1; cmd_data = 4'h1;
    step();
    cmd_we = 1'b0;
    step();
    chk("setwins_irq", 32'(irq), 32'd1);
    chk("setwins_frame", 32'(frame_cnt), 32'd1);
    cmd_we = 1'b1; cmd_data = 4'h1;
    step();
    cmd_we = 1'b0;
    step();
    chk("irq_clr3", 32'(irq), 32'd0);

    // auto mode
    cmd_we = 1'b1; cmd_data = 4'h8;
    step();
    cmd_we = 1'b0;
    step();
    chk("a1_valid", 32'(status_valid), 32'd1);
    chk("a1_word", 32'(status_word), 32'h0850);
    status = 3'b001;
    step();
    status = 3'b000;
    step();
    chk("a1_frozen", 32'(status_word), 32'h0850);
    status_ack = 1'b1;
    step();
    chk("a1_ack", 32'(status_valid), 32'd0);
    status_ack = 1'b0;
    step();
    chk("a2_valid", 32'(status_valid), 32'd1);
    chk("a2_word", 32'(status_word), 32'h0C50);
    status_ack = 1'b1;
    step();
    chk("a2_ack", 32'(status_valid), 32'd0);
    step();
    chk("a_idle_ack", 32'(status_valid), 32'd0);
    status_ack = 1'b0;
    step();
    chk("a_noextra", 32'(status_valid), 32'd0);
    status = 3'b010;
    step();
    step();
    chk("a3_valid", 32'(status_valid), 32'd1);
    chk("a3_word", 32'(status_word), 32'h1052);

    // reset mid-handshake
    #2;
    mrst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(status_valid), 32'd0);
    chk("mid_rst_word", 32'(status_word), 32'd0);
    chk("mid_rst_frame", 32'(frame_cnt), 32'd0);
    step();
    mrst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(status_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
